uart_hex_streamer: RTL and testbench

- Byte-to-ASCII-hex formatter that drives the TxD_start / TxD_data / TxD_busy handshake of the team's async UART transmitter.
- Producers (e.g. the TWI bus monitor) push raw bytes with an optional end-of-packet flag into a small FIFO.
- The block emits each byte as two uppercase hex characters followed by a separator (space, or CR LF at end of packet or end of line).
- Sits between the capture logic and the UART TX, so a serial terminal shows readable traffic.

---
 rtl/uart_hex_pkg.sv | 30 +++
 rtl/hex_stream_fifo.sv | 59 +++++
 rtl/uart_hex_streamer.sv | 175 +++++++++++++++++
 tb/tb_uart_hex_streamer.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_hex_pkg.sv
// Shared constants, FSM state encoding and nibble-to-ASCII helper for the UART hex streamer.
// Optional macro UART_HEX_OVF_MARK_EN adds the MARK state used for the overflow marker.
package uart_hex_pkg;

  localparam logic [7:0] ASC_SP   = 8'h20;
  localparam logic [7:0] ASC_CR   = 8'h0D;
  localparam logic [7:0] ASC_LF   = 8'h0A;
  localparam logic [7:0] ASC_BANG = 8'h21;

  typedef enum logic [2:0] {
    IDLE,
    HI,
    LO,
    SEP,
    CR,
    LF,
    HOLD
`ifdef UART_HEX_OVF_MARK_EN
    , MARK
`endif
  } hex_state_t;

  // Uppercase hex digit: '0'..'9' then 'A'..'F'.
  function automatic logic [7:0] nib2ascii(input logic [3:0] nib);
    logic [7:0] wide;
    wide = {4'h0, nib};
    return (nib < 4'd10) ? (8'h30 + wide) : (8'h37 + wide);
  endfunction

endpackage

// File: rtl/hex_stream_fifo.sv
// Synchronous FIFO with registered count; pushes while full and pops while empty are ignored.
// Read data is presented combinationally from the head entry.
module hex_stream_fifo
  import uart_hex_pkg::*;
#(
  parameter int WIDTH = 9,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push_ok, pop_ok;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign rdata   = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(push_ok);
    rd_ptr_d = rd_ptr_q + AW'(pop_ok);
    count_d  = count_q + CW'(push_ok) - CW'(pop_ok);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; the count alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

endmodule

// File: rtl/uart_hex_streamer.sv
// Formats queued bytes as two uppercase hex characters plus a space or CR LF for a UART transmitter.
// Optional macro UART_HEX_OVF_MARK_EN sends '!' before the first byte printed after a drop.
module uart_hex_streamer
  import uart_hex_pkg::*;
#(
  parameter int DEPTH      = 8,
  parameter int LINE_BYTES = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  input  logic       in_eop,
  output logic       in_ready,
  output logic       drop,
  output logic       tx_start,
  output logic [7:0] tx_data,
  input  logic       tx_busy,
  output logic       idle
);

  localparam int LCW = $clog2(LINE_BYTES + 1);

  hex_state_t     state_q, state_d;
  hex_state_t     next_q, next_d;
  logic [7:0]     cur_byte_q, cur_byte_d;
  logic           cur_eop_q, cur_eop_d;
  logic [LCW-1:0] line_cnt_q, line_cnt_d;
  logic [7:0]     tx_data_q, tx_data_d;
  logic           start;
  logic [7:0]     chr;
  logic           fifo_full, fifo_empty, fifo_pop;
  logic [8:0]     fifo_rdata;
`ifdef UART_HEX_OVF_MARK_EN
  logic           ovf_pending_q, ovf_pending_d;
`endif

  assign in_ready = !fifo_full;
  assign drop     = in_valid && fifo_full;
  assign tx_start = start;
  assign tx_data  = tx_data_d;
  assign idle     = fifo_empty && (state_q == IDLE);

  hex_stream_fifo #(
    .WIDTH (9),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (in_valid && !fifo_full),
    .wdata ({in_eop, in_data}),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Every character state waits for an idle transmitter, fires one start pulse, then passes through HOLD.
  always_comb begin
    state_d    = state_q;
    next_d     = next_q;
    cur_byte_d = cur_byte_q;
    cur_eop_d  = cur_eop_q;
    line_cnt_d = line_cnt_q;
    fifo_pop   = 1'b0;
    start      = 1'b0;
    chr        = tx_data_q;
`ifdef UART_HEX_OVF_MARK_EN
    ovf_pending_d = ovf_pending_q || drop;
`endif
    unique case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop   = 1'b1;
          cur_byte_d = fifo_rdata[7:0];
          cur_eop_d  = fifo_rdata[8];
          state_d    = HI;
`ifdef UART_HEX_OVF_MARK_EN
          if (ovf_pending_q) state_d = MARK;
`endif
        end
      end
      HI: begin
        if (!tx_busy) begin
          start   = 1'b1;
          chr     = nib2ascii(cur_byte_q[7:4]);
          next_d  = LO;
          state_d = HOLD;
        end
      end
      LO: begin
        if (!tx_busy) begin
          start   = 1'b1;
          chr     = nib2ascii(cur_byte_q[3:0]);
          state_d = HOLD;
          if (cur_eop_q || (line_cnt_q == LCW'(LINE_BYTES - 1))) begin
            next_d     = CR;
            line_cnt_d = '0;
          end else begin
            next_d     = SEP;
            line_cnt_d = line_cnt_q + LCW'(1);
          end
        end
      end
      SEP: begin
        if (!tx_busy) begin
          start   = 1'b1;
          chr     = ASC_SP;
          next_d  = IDLE;
          state_d = HOLD;
        end
      end
      CR: begin
        if (!tx_busy) begin
          start   = 1'b1;
          chr     = ASC_CR;
          next_d  = LF;
          state_d = HOLD;
        end
      end
      LF: begin
        if (!tx_busy) begin
          start   = 1'b1;
          chr     = ASC_LF;
          next_d  = IDLE;
          state_d = HOLD;
        end
      end
      HOLD: begin
        state_d = next_q;
      end
`ifdef UART_HEX_OVF_MARK_EN
      // A drop in the same cycle as the marker keeps the flag set.
      MARK: begin
        if (!tx_busy) begin
          start         = 1'b1;
          chr           = ASC_BANG;
          next_d        = HI;
          state_d       = HOLD;
          ovf_pending_d = drop;
        end
      end
`endif
      default: begin
        state_d = IDLE;
      end
    endcase
    tx_data_d = start ? chr : tx_data_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      next_q     <= IDLE;
      cur_byte_q <= '0;
      cur_eop_q  <= 1'b0;
      line_cnt_q <= '0;
      tx_data_q  <= '0;
`ifdef UART_HEX_OVF_MARK_EN
      ovf_pending_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      next_q     <= next_d;
      cur_byte_q <= cur_byte_d;
      cur_eop_q  <= cur_eop_d;
      line_cnt_q <= line_cnt_d;
      tx_data_q  <= tx_data_d;
`ifdef UART_HEX_OVF_MARK_EN
      ovf_pending_q <= ovf_pending_d;
`endif
    end
  end

endmodule

// File: tb/tb_uart_hex_streamer.sv
// Self-checking bench for uart_hex_streamer: byte vectors feed a character scoreboard
// that a busy-modelling transmitter monitor drains, plus hand-written overflow and reset sequences.
module tb_uart_hex_streamer;

   localparam int DEPTH      = 8;
   localparam int LINE_BYTES = 4;
   localparam int BUSY_CYCLES = 10;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       in_valid = 1'b0;
   logic [7:0] in_data = 8'h00;
   logic       in_eop = 1'b0;
   logic       in_ready;
   logic       drop;
   logic       tx_start;
   logic [7:0] tx_data;
   logic       tx_busy;
   logic       idle;

   int         testsRun = 0;
   int         testsFailed = 0;
   int         busyCnt = 0;
   logic       holdBusy = 1'b0;
   logic       prevStart = 1'b0;
   int         dropCount = 0;
   int         modelLine = 0;
   logic [7:0] expQ[$];
   logic [7:0] expChar;

   typedef struct {
      logic [7:0] data;
      logic       eop;
      logic       accept;
   } vec_t;

   vec_t vecs[8];

   uart_hex_streamer #(
      .DEPTH      (DEPTH),
      .LINE_BYTES (LINE_BYTES)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (in_valid),
      .in_data  (in_data),
      .in_eop   (in_eop),
      .in_ready (in_ready),
      .drop     (drop),
      .tx_start (tx_start),
      .tx_data  (tx_data),
      .tx_busy  (tx_busy),
      .idle     (idle)
   );

   always #5 clk = ~clk;

   // Transmitter stand-in: busy from the cycle after a start pulse, independent of the streamer reset.
   always @(posedge clk) begin
      if (tx_start) busyCnt <= BUSY_CYCLES;
      else if (busyCnt > 0) busyCnt <= busyCnt - 1;
   end
   assign tx_busy = holdBusy || (busyCnt != 0);

   always @(posedge clk) begin
      if (drop) dropCount <= dropCount + 1;
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      testsRun++;
      if (actual !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
      end
   endtask

   function automatic logic [7:0] hexChar(input logic [3:0] n);
      string digits;
      digits = "0123456789ABCDEF";
      return digits[n];
   endfunction

   // Reference formatter: queues the characters one accepted byte should produce.
   task automatic modelByte(input logic [7:0] data, input logic eop);
      expQ.push_back(hexChar(data[7:4]));
      expQ.push_back(hexChar(data[3:0]));
      if (eop || modelLine == LINE_BYTES - 1) begin
         expQ.push_back(8'h0D);
         expQ.push_back(8'h0A);
         modelLine = 0;
      end else begin
         expQ.push_back(8'h20);
         modelLine++;
      end
   endtask

   // Character monitor: every start pulse must meet an idle transmitter and match the scoreboard head.
   always @(negedge clk) begin
      if (rst_n) begin
         if (prevStart) checkOutput("start_width", {31'd0, tx_start}, 32'd0);
         if (tx_start) begin
            checkOutput("start_while_busy", {31'd0, tx_busy}, 32'd0);
            checkOutput("start_expected", {31'd0, expQ.size() != 0}, 32'd1);
            if (expQ.size() != 0) begin
               expChar = expQ.pop_front();
               checkOutput("tx_data", {24'd0, tx_data}, {24'd0, expChar});
            end
         end
         prevStart = tx_start;
      end else begin
         prevStart = 1'b0;
      end
   end

   task automatic applyStimulus(input logic [7:0] data, input logic eop, input logic accept, input logic modelIt);
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = data;
      in_eop   = eop;
      #1;
      checkOutput("in_ready", {31'd0, in_ready}, {31'd0, accept});
      checkOutput("drop", {31'd0, drop}, {31'd0, !accept});
      @(posedge clk);
      if (accept && modelIt) modelByte(data, eop);
      #1;
      in_valid = 1'b0;
      in_eop   = 1'b0;
   endtask

   task automatic waitDrain(input int budget);
      int n;
      n = 0;
      while ((expQ.size() != 0 || !idle || tx_busy) && n < budget) begin
         @(negedge clk);
         n++;
      end
      checkOutput("drain_queue", expQ.size(), 32'd0);
      checkOutput("drain_idle", {31'd0, idle}, 32'd1);
   endtask

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not finish, %0d tests run", testsRun);
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int dropsBefore;
      int n;

      vecs[0] = '{8'hF0, 1'b0, 1'b1};
      vecs[1] = '{8'h07, 1'b1, 1'b1};
      vecs[2] = '{8'h00, 1'b0, 1'b1};
      vecs[3] = '{8'h01, 1'b0, 1'b1};
      vecs[4] = '{8'h02, 1'b0, 1'b1};
      vecs[5] = '{8'h03, 1'b0, 1'b1};
      vecs[6] = '{8'h04, 1'b0, 1'b1};
      vecs[7] = '{8'h05, 1'b0, 1'b1};

      // Reset values
      repeat (3) @(negedge clk);
      checkOutput("rst_in_ready", {31'd0, in_ready}, 32'd1);
      checkOutput("rst_idle", {31'd0, idle}, 32'd1);
      checkOutput("rst_tx_start", {31'd0, tx_start}, 32'd0);
      checkOutput("rst_tx_data", {24'd0, tx_data}, 32'd0);
      checkOutput("rst_drop", {31'd0, drop}, 32'd0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // Single byte 0x3A and first-character latency
      applyStimulus(8'h3A, 1'b0, 1'b1, 1'b1);
      @(negedge clk);
      checkOutput("latency_early", {31'd0, tx_start}, 32'd0);
      @(negedge clk);
      checkOutput("latency_start", {31'd0, tx_start}, 32'd1);
      checkOutput("latency_data", {24'd0, tx_data}, 32'h33);
      waitDrain(500);

      // End of packet and forced line break from the vector table
      for (int i = 0; i < 8; i++) begin
         applyStimulus(vecs[i].data, vecs[i].eop, vecs[i].accept, 1'b1);
      end
      waitDrain(3000);

      // Overflow with the transmitter held busy
      holdBusy = 1'b1;
      applyStimulus(8'h11, 1'b0, 1'b1, 1'b1);
      repeat (3) @(negedge clk);
      dropsBefore = dropCount;
      for (int i = 0; i < DEPTH + 2; i++) begin
`ifdef UART_HEX_OVF_MARK_EN
         if (i == 0) expQ.push_back(8'h21);
`endif
         applyStimulus(8'h80 + 8'(i), 1'b0, i < DEPTH, 1'b1);
      end
      @(negedge clk);
      checkOutput("full_in_ready", {31'd0, in_ready}, 32'd0);
      checkOutput("drop_pulses", dropCount - dropsBefore, 32'd2);
      holdBusy = 1'b0;
      waitDrain(5000);
      checkOutput("after_ovf_in_ready", {31'd0, in_ready}, 32'd1);

      // Reset after the high-nibble character of 0xA5
      applyStimulus(8'hA5, 1'b0, 1'b1, 1'b0);
      expQ.push_back(hexChar(4'hA));
      n = 0;
      while (expQ.size() != 0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      checkOutput("mid_hi_sent", expQ.size(), 32'd0);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      checkOutput("midrst_tx_start", {31'd0, tx_start}, 32'd0);
      checkOutput("midrst_idle", {31'd0, idle}, 32'd1);
      checkOutput("midrst_in_ready", {31'd0, in_ready}, 32'd1);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      modelLine = 0;
      repeat (30) @(negedge clk);
      applyStimulus(8'h5C, 1'b0, 1'b1, 1'b1);
      waitDrain(500);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
